// File: rtl/vga_text_reader.sv
// vga_text_reader: 640x480@60 VGA scan-out of a 40x16 text buffer with a blinking underline cursor
// Ports:
//   clk, reset        pixel clock (25 MHz), asynchronous active-low reset
//   raddr, rdata      text RAM read port {row[3:0], col[6:0]}; data one cycle after address
//   font_addr         font ROM address {code[6:0], frow[3:0]}
//   font_data         glyph row, bit7 = leftmost pixel; one cycle after font_addr
//   cursor_addr       cursor cell, same format as raddr
//   cursor_en         cursor visible when 1
//   R, G, B           3-bit colour channels, three cycles behind the counters
//   Hs, Vs            active-low syncs, delayed with the pixel data
module vga_text_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter logic [8:0] FG = 9'b111111111,
  parameter logic [8:0] BG = 9'b000000000,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] raddr,
  input  logic [7:0]  rdata,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [10:0] cursor_addr,
  input  logic        cursor_en,
  output logic [2:0]  R,
  output logic [2:0]  G,
  output logic [2:0]  B,
  output logic        Hs,
  output logic        Vs
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] HS_ON = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0] F_LAST = 8'(BLINK_FRAMES - 1);
  logic [9:0] h_q, h_d, v_q, v_d;
  logic [4:0] sub_q, sub_d;
  logic [3:0] row_q, row_d;
  logic [7:0] frame_q, frame_d;
  logic       blink_q, blink_d;
  logic       h_end, v_end, sub_end, frame_end;
  logic       act0, hs0, vs0, hit0, code_ok, pix;
  logic [3:0] frow0;
  logic [3:0] p1_frow_q;
  logic [2:0] p1_bit_q, p2_bit_q;
  logic [3:0] p1_flag_q, p2_flag_q;
  logic       p2_ok_q;
  logic [8:0] rgb_q, rgb_d;
  logic       hs_q, vs_q;
  // Scan counters. sub_q is v mod 30 and row_q is v / 30, kept incrementally to avoid a divider;
  // row_q may wrap during vertical blanking, where it is never used.
  always_comb begin
    h_end = h_q == H_LAST;
    v_end = v_q == V_LAST;
    sub_end = sub_q == 5'd29;
    frame_end = frame_q == F_LAST;
    h_d = h_end ? '0 : h_q + 10'd1;
    v_d = !h_end ? v_q : v_end ? '0 : v_q + 10'd1;
    sub_d = !h_end ? sub_q : (v_end || sub_end) ? '0 : sub_q + 5'd1;
    row_d = !h_end ? row_q : v_end ? '0 : row_q + {3'd0, sub_end};
    frame_d = !(h_end && v_end) ? frame_q : frame_end ? '0 : frame_q + 8'd1;
    blink_d = blink_q ^ (h_end && v_end && frame_end);
  end
  // Stage 0: text RAM address and per-pixel flags straight from the counters.
  // Flags are packed {active, hs, vs, cursor_hit}.
  always_comb begin
    act0 = h_q < H_ACT && v_q < V_ACT;
    raddr = act0 ? {row_q, 1'b0, h_q[9:4]} : '0;
    frow0 = sub_q[4:1];
    hs0 = !(h_q >= HS_ON && h_q < HS_OFF);
    vs0 = !(v_q >= VS_ON && v_q < VS_OFF);
    hit0 = cursor_en && blink_q && act0 && cursor_addr == raddr && frow0 >= 4'd13;
  end
  // Stage 1: character code arrives; codes above 95 fetch glyph 0 and are blanked later.
  always_comb begin
    code_ok = rdata < 8'd96;
    font_addr = {code_ok ? rdata[6:0] : 7'd0, p1_frow_q};
  end
  // Stage 2: glyph row arrives; pick the bit for this pixel pair.
  always_comb begin
    pix = p2_flag_q[3] && (p2_flag_q[0] || (p2_ok_q && font_data[p2_bit_q]));
    rgb_d = !p2_flag_q[3] ? '0 : pix ? FG : BG;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q <= '0;
      v_q <= '0;
      sub_q <= '0;
      row_q <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
      p1_frow_q <= '0;
      p1_bit_q <= '0;
      p1_flag_q <= 4'b0110;
      p2_bit_q <= '0;
      p2_flag_q <= 4'b0110;
      p2_ok_q <= 1'b0;
      rgb_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      sub_q <= sub_d;
      row_q <= row_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      p1_frow_q <= frow0;
      p1_bit_q <= ~h_q[3:1];
      p1_flag_q <= {act0, hs0, vs0, hit0};
      p2_bit_q <= p1_bit_q;
      p2_flag_q <= p1_flag_q;
      p2_ok_q <= code_ok;
      rgb_q <= rgb_d;
      hs_q <= p2_flag_q[2];
      vs_q <= p2_flag_q[1];
    end
  end
  assign R = rgb_q[8:6];
  assign G = rgb_q[5:3];
  assign B = rgb_q[2:0];
  assign Hs = hs_q;
  assign Vs = vs_q;
endmodule
